// File: rtl/mmio_responder_pkg.sv
// Shared IO-window constants: base address, register byte offsets, zero word, glyph table.
// Combinational helpers only; no state, no flow control.
package mmio_responder_pkg;

  localparam logic [31:0] IO_BASE_ADDR = 32'hFFFF_FC00;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  // Byte offsets within the 32-byte window; compared against {io_addr[4:2], 2'b00}.
  localparam logic [4:0] LED_OFF   = 5'h00;
  localparam logic [4:0] SW_OFF    = 5'h04;
  localparam logic [4:0] SEG_OFF   = 5'h08;
  localparam logic [4:0] BTN_OFF   = 5'h0C;
  localparam logic [4:0] TIMER_OFF = 5'h10;

  // Active-low {dp,g,f,e,d,c,b,a}; dp held off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// Memory-stage IO port: address/store strobe toward the responder, load data back.
// Read data is combinational in the same cycle; no backpressure, stores are 1-cycle qualified.
interface mmio_if;
  logic [31:0] io_addr;
  logic [31:0] io_write_data;
  logic        io_we;
  logic [31:0] io_read_data;

  modport master (output io_addr, output io_write_data, output io_we, input io_read_data);
  modport slave  (input io_addr, input io_write_data, input io_we, output io_read_data);
endinterface

// File: rtl/mmio_responder_seg7_scan.sv
// Eight-digit multiplexed hex display driver; each digit held for SCAN_DIV clk cycles.
// Outputs registered, aligned with the current digit index; no backpressure.
module seg7_scan
  import mmio_responder_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_val,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [2:0]       idx_nxt;
  logic             slot_end;

  always_comb begin
    slot_end = (cnt_q == CNT_W'(SCAN_DIV - 1));
    idx_nxt  = slot_end ? idx_q + 3'd1 : idx_q;
  end

  // Outputs are built from the next index so they change on the same edge as idx_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      seg_an  <= 8'hFE;
      seg_cat <= 8'hC0;
    end else begin
      cnt_q   <= slot_end ? '0 : cnt_q + 1'b1;
      idx_q   <= idx_nxt;
      seg_an  <= ~(8'd1 << idx_nxt);
      seg_cat <= hex_glyph(seg_val[{idx_nxt, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Board IO responder: LED, switches, buttons (BTN_DEBOUNCE_EN adds debounce), 7-seg, tick timer.
// Reads combinational same cycle, writes commit at the next clk edge; never stalls the pipeline.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = IO_BASE_ADDR,
  parameter int          SCAN_DIV   = 100000,
  parameter int          TICK_DIV   = 100000,
  parameter int          DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  mmio_if.slave       io,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int PRE_W = $clog2((TICK_DIV > 1) ? TICK_DIV : 2);

  logic             hit;
  logic [4:0]       off;
  logic             wr;
  logic [15:0]      led_q;
  logic [31:0]      seg_q;
  logic [31:0]      timer_q;
  logic [PRE_W-1:0] pre_q;
  logic [15:0]      sw_s1, sw_s2;
  logic [4:0]       btn_s1, btn_s2;
  logic [4:0]       btn_val;
  logic [31:0]      rd_data;
  logic             unused_ok;

  assign hit       = (io.io_addr[31:5] == IO_BASE[31:5]);
  assign off       = {io.io_addr[4:2], 2'b00};
  assign wr        = io.io_we & hit;
  assign unused_ok = &{1'b0, io.io_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= '0;
      seg_q  <= ZERO_WORD;
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      if (wr && off == LED_OFF) led_q <= io.io_write_data[15:0];
      if (wr && off == SEG_OFF) seg_q <= io.io_write_data;
      sw_s1  <= sw_in;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // A clearing write outranks a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= ZERO_WORD;
      pre_q   <= '0;
    end else if (wr && off == TIMER_OFF) begin
      timer_q <= ZERO_WORD;
      pre_q   <= '0;
    end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
      timer_q <= timer_q + 32'd1;
      pre_q   <= '0;
    end else begin
      pre_q   <= pre_q + 1'b1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt [5];
  logic [4:0]       btn_q;

  // Counter runs only while the synced input disagrees with the accepted state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (btn_s2[i] != btn_q[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            btn_q[i]   <= btn_s2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign btn_val = btn_q;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;
  assign btn_val = btn_s2;
`endif

  always_comb begin
    rd_data = ZERO_WORD;
    if (!rst && hit) begin
      case (off)
        LED_OFF:   rd_data = {16'h0000, led_q};
        SW_OFF:    rd_data = {16'h0000, sw_s2};
        SEG_OFF:   rd_data = seg_q;
        BTN_OFF:   rd_data = {27'd0, btn_val};
        TIMER_OFF: rd_data = timer_q;
        default:   rd_data = ZERO_WORD;
      endcase
    end
  end

  assign io.io_read_data = rd_data;
  assign led_out         = led_q;

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_seg7_scan (
    .clk     (clk),
    .rst     (rst),
    .seg_val (seg_q),
    .seg_an  (seg_an),
    .seg_cat (seg_cat)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder with SCAN_DIV=4, TICK_DIV=3, DEB_CYCLES=5.
module tb_mmio_responder;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_in = '0;
  logic [4:0]  btn_in = '0;
  logic [15:0] led_out;
  logic [7:0]  seg_an, seg_cat;
  int          tests = 0;
  int          fails = 0;

  mmio_if bus();

  mmio_responder #(.IO_BASE(BASE), .SCAN_DIV(4), .TICK_DIV(3), .DEB_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .io(bus), .sw_in(sw_in), .btn_in(btn_in),
    .led_out(led_out), .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the store commits on the following posedge, returns at the next negedge.
  task automatic write_io(input logic [31:0] addr, input logic [31:0] data);
    bus.io_addr = addr; bus.io_write_data = data; bus.io_we = 1'b1;
    @(negedge clk);
    bus.io_we = 1'b0;
  endtask

  task automatic read_io(input logic [31:0] addr, output logic [31:0] data);
    bus.io_addr = addr;
    #1;
    data = bus.io_read_data;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (2) @(negedge clk);
    tests++;
    if (led_out !== 16'h0 || seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      fails++; $display("FAIL reset_outputs: led=%h an=%h cat=%h, need 0000/FE/C0", led_out, seg_an, seg_cat);
    end
    rst = 1'b0;
    @(negedge clk);
    write_io(BASE, 32'h0000_00AA);
    repeat (5) @(negedge clk);
    tests++;
    if (led_out !== 16'h00AA) begin fails++; $display("FAIL pre_reset_led: got %h need 00aa", led_out); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (led_out !== 16'h0 || seg_an !== 8'hFE || seg_cat !== 8'hC0) begin
      fails++; $display("FAIL async_reset: led=%h an=%h cat=%h, need 0000/FE/C0", led_out, seg_an, seg_cat);
    end
    for (int a = 0; a < 32; a += 4) begin
      read_io(BASE + a, rd);
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL read_in_reset off=%0h: got %h need 0", a, rd); end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    read_io(BASE, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL led_after_reset: got %h need 0", rd); end
  endtask

  task automatic test_switch();
    logic [31:0] rd;
    sw_in = 16'hA5A5;
    @(negedge clk);
    read_io(BASE + 32'h4, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL sw_sync_1edge: got %h need 0", rd); end
    @(negedge clk);
    read_io(BASE + 32'h4, rd);
    tests++;
    if (rd !== 32'h0000_A5A5) begin fails++; $display("FAIL sw_sync_2edge: got %h need 0000a5a5", rd); end
    read_io(32'h0000_1004, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL miss_read: got %h need 0", rd); end
  endtask

  task automatic test_led();
    logic [31:0] rd;
    write_io(BASE, 32'hFFFF_1234);
    read_io(BASE, rd);
    tests++;
    if (led_out !== 16'h1234 || rd !== 32'h0000_1234) begin
      fails++; $display("FAIL led_roundtrip: led=%h rd=%h need 1234/00001234", led_out, rd);
    end
    read_io(BASE + 32'h2, rd);
    tests++;
    if (rd !== 32'h0000_1234) begin fails++; $display("FAIL led_byte_lanes: got %h need 00001234", rd); end
    write_io(BASE + 32'h4, 32'h0000_DEAD);
    read_io(BASE + 32'h4, rd);
    tests++;
    if (rd !== 32'h0000_A5A5) begin fails++; $display("FAIL sw_write_ignored: got %h need 0000a5a5", rd); end
    write_io(32'h0000_1000, 32'h0000_5555);
    tests++;
    if (led_out !== 16'h1234) begin fails++; $display("FAIL miss_write: led=%h need 1234", led_out); end
    write_io(BASE + 32'h14, 32'hFFFF_FFFF);
    read_io(BASE + 32'h14, rd);
    tests++;
    if (rd !== 32'h0 || led_out !== 16'h1234) begin
      fails++; $display("FAIL unmapped_write: rd=%h led=%h need 0/1234", rd, led_out);
    end
  endtask

  task automatic test_seg();
    logic [7:0]  exp_cat [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    logic [7:0]  exp_an;
    logic [31:0] rd;
    int          n;
    write_io(BASE + 32'h8, 32'h0123_4567);
    read_io(BASE + 32'h8, rd);
    tests++;
    if (rd !== 32'h0123_4567) begin fails++; $display("FAIL seg_readback: got %h need 01234567", rd); end
    n = 0;
    while (seg_an !== 8'h7F && n < 40) begin @(negedge clk); n++; end
    while (seg_an !== 8'hFE && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (n >= 50) begin fails++; $display("FAIL seg_scan_sync: an=%h never wrapped to fe", seg_an); end
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'd1 << d);
      tests++;
      if (seg_an !== exp_an || seg_cat !== exp_cat[d]) begin
        fails++; $display("FAIL seg_digit%0d: an=%h cat=%h need %h/%h", d, seg_an, seg_cat, exp_an, exp_cat[d]);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
    write_io(BASE + 32'h10, 32'h0);
    repeat (9) @(negedge clk);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'd3) begin fails++; $display("FAIL timer_9cycles: got %h need 3", rd); end
    repeat (2) @(negedge clk);
    write_io(BASE + 32'h10, 32'h1234_5678);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL timer_write_wins: got %h need 0", rd); end
    repeat (2) @(negedge clk);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'd0) begin fails++; $display("FAIL timer_prescaler_cleared: got %h need 0", rd); end
    @(negedge clk);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'd1) begin fails++; $display("FAIL timer_after_clear: got %h need 1", rd); end
    write_io(BASE + 32'h10, 32'h0);
    force dut.timer_q = 32'hFFFF_FFFF;
    #1 release dut.timer_q;
    repeat (2) @(negedge clk);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL timer_max_hold: got %h need ffffffff", rd); end
    @(negedge clk);
    read_io(BASE + 32'h10, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL timer_wrap: got %h need 0", rd); end
  endtask

  task automatic test_button();
    logic [31:0] rd;
`ifdef BTN_DEBOUNCE_EN
    btn_in = 5'b00100;
    repeat (3) @(negedge clk);
    btn_in = 5'b0;
    repeat (8) @(negedge clk);
    read_io(BASE + 32'hC, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL btn_glitch: got %h need 0", rd); end
    btn_in = 5'b00100;
    repeat (6) @(negedge clk);
    read_io(BASE + 32'hC, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL btn_deb_early: got %h need 0", rd); end
    @(negedge clk);
    read_io(BASE + 32'hC, rd);
    tests++;
    if (rd !== 32'h4) begin fails++; $display("FAIL btn_deb_accept: got %h need 4", rd); end
`else
    btn_in = 5'b00100;
    @(negedge clk);
    read_io(BASE + 32'hC, rd);
    tests++;
    if (rd !== 32'h0) begin fails++; $display("FAIL btn_sync_1edge: got %h need 0", rd); end
    @(negedge clk);
    read_io(BASE + 32'hC, rd);
    tests++;
    if (rd !== 32'h4) begin fails++; $display("FAIL btn_sync_2edge: got %h need 4", rd); end
`endif
    btn_in = 5'b0;
  endtask

  initial begin
    bus.io_addr = BASE; bus.io_write_data = '0; bus.io_we = 1'b0;
    test_reset();
    test_switch();
    test_led();
    test_seg();
    test_timer();
    test_button();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
